// File: rtl/inst_fetch_buffer_if.sv
// Instruction memory bus between the fetch buffer and instruction memory.
//   mem_req    : fetch request valid (fetcher -> memory)
//   mem_addr   : word address of the request (fetcher -> memory)
//   mem_gnt    : request accepted this cycle (memory -> fetcher)
//   mem_rvalid : response valid, earliest the cycle after mem_gnt (memory -> fetcher)
//   mem_rdata  : response word (memory -> fetcher)
//   mem_err    : bus error, qualified by mem_rvalid (memory -> fetcher)
interface inst_fetch_buffer_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        mem_err;

    modport master (
        output mem_req, mem_addr,
        input  mem_gnt, mem_rvalid, mem_rdata, mem_err
    );

    modport slave (
        input  mem_req, mem_addr,
        output mem_gnt, mem_rvalid, mem_rdata, mem_err
    );
endinterface

// File: rtl/inst_fetch_buffer.sv
// Prefetching instruction buffer feeding the MIPS32 Decode stage.
// Issues sequential word fetches with at most one request outstanding and
// queues the returned words together with their PCs in a DEPTH-entry FIFO.
// The head entry is presented to Decode with the core's 2-bit readiness
// encoding. A redirect flushes the queue and discards any in-flight response.
//   clk, rst          : clock, asynchronous active-low reset
//   redirect          : flush and restart fetching at redirect_pc
//   redirect_pc       : new word-aligned fetch address
//   stall             : Decode hold, head is not consumed while high
//   mem               : instruction memory bus (master side)
//   pc, inst          : head PC and instruction (fetch_pc / 0 when empty)
//   inst_status       : 2'b00 empty, 2'b10 valid, 2'b01 fault
module inst_fetch_buffer #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                redirect,
    input  logic [31:0]         redirect_pc,
    input  logic                stall,
    inst_fetch_buffer_if.master mem,
    output logic [31:0]         pc,
    output logic [31:0]         inst,
    output logic [1:0]          inst_status
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

    state_t           state, state_next;
    logic [31:0]      fetch_pc, req_pc;
    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic [CNT_W-1:0] count;

    logic [31:0]      fifo_pc   [DEPTH];
    logic [31:0]      fifo_inst [DEPTH];
    logic             fifo_err  [DEPTH];

    logic             issue;
    logic             push;
    logic             pop;
    logic             head_valid;

    // Head presentation depends only on stored state, never on the bus.
    assign head_valid  = (count != '0);
    assign inst_status = !head_valid        ? 2'b00 :
                         fifo_err[rd_ptr]   ? 2'b01 : 2'b10;
    assign inst        = head_valid ? fifo_inst[rd_ptr] : 32'd0;
    assign pc          = head_valid ? fifo_pc[rd_ptr]   : fetch_pc;
    assign mem.mem_addr = fetch_pc;

    // A fault head is never consumed; only a redirect clears it.
    assign pop = (inst_status == 2'b10) && !stall && !redirect;

    // Fetch sequencing: one request in flight; a redirect during the wait
    // turns the pending response into one that must be thrown away.
    always_comb begin
        state_next  = state;
        mem.mem_req = 1'b0;
        issue       = 1'b0;
        push        = 1'b0;
        unique case (state)
            IDLE: begin
                mem.mem_req = (count < FULL) && !redirect;
                if (mem.mem_req && mem.mem_gnt) begin
                    issue      = 1'b1;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (mem.mem_rvalid) begin
                    push       = !redirect;
                    state_next = IDLE;
                end else if (redirect) begin
                    state_next = DROP;
                end
            end
            DROP: begin
                if (mem.mem_rvalid) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Fetch address tracking; redirect wins over advancing past a grant.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc <= RESET_PC;
            req_pc   <= RESET_PC;
        end else begin
            if (issue) begin
                req_pc <= fetch_pc;
            end
            if (redirect) begin
                fetch_pc <= redirect_pc;
            end else if (issue) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
        end
    end

    // Queue occupancy and pointers; redirect empties the queue outright.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (redirect) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    // Entry storage needs no reset: count gates every read of it.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc[wr_ptr]   <= req_pc;
            fifo_inst[wr_ptr] <= mem.mem_rdata;
            fifo_err[wr_ptr]  <= mem.mem_err;
        end
    end
endmodule

// File: tb/tb_inst_fetch_buffer.sv
// Self-checking bench for inst_fetch_buffer: a queue-based reference model
// of the buffer, one compare process checking every cycle, and directed
// scenarios with hand-computed literal expectations.
module tb_inst_fetch_buffer;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0040_0000;

    logic        clk;
    logic        rst;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        stall;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [1:0]  inst_status;

    inst_fetch_buffer_if bus();

    inst_fetch_buffer #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk         (clk),
        .rst         (rst),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .stall       (stall),
        .mem         (bus),
        .pc          (pc),
        .inst        (inst),
        .inst_status (inst_status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 0;

    // Memory responder state.
    bit          pend_valid;
    int          pend_delay;
    logic [31:0] pend_addr;
    int          lat;
    bit          resp_hold;
    bit          data_override;
    logic [31:0] override_data;
    bit          err_en;
    logic [31:0] err_addr;

    logic [31:0] hs_log[$];
    logic [31:0] pop_log[$];

    // Reference model: queue of entries, next fetch address, and the single
    // outstanding request with a flag saying whether its data is still wanted.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        err;
    } entry_t;

    entry_t      m_q[$];
    logic [31:0] m_fetch_pc;
    logic [31:0] m_out_pc;
    bit          m_out;
    bit          m_keep;
    logic [31:0] m_popped[$];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Model update on each clock edge, with asynchronous reset.
    initial begin
        m_fetch_pc = RESET_PC;
        m_out      = 0;
        m_keep     = 0;
        m_out_pc   = '0;
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                m_q.delete();
                m_fetch_pc = RESET_PC;
                m_out      = 0;
                m_keep     = 0;
            end else begin
                bit     do_pop;
                bit     grant;
                entry_t e;
                do_pop = (m_q.size() > 0) && !m_q[0].err && !stall && !redirect;
                grant  = !m_out && (m_q.size() < DEPTH) && !redirect && bus.mem_gnt;
                if (do_pop) begin
                    m_popped.push_back(m_q[0].pc);
                    void'(m_q.pop_front());
                end
                if (m_out && bus.mem_rvalid) begin
                    if (m_keep && !redirect) begin
                        e.pc   = m_out_pc;
                        e.inst = bus.mem_rdata;
                        e.err  = bus.mem_err;
                        m_q.push_back(e);
                    end
                    m_out = 0;
                end
                if (grant) begin
                    m_out      = 1;
                    m_keep     = 1;
                    m_out_pc   = m_fetch_pc;
                    m_fetch_pc = m_fetch_pc + 32'd4;
                end
                if (redirect) begin
                    m_q.delete();
                    m_fetch_pc = redirect_pc;
                    m_keep     = 0;
                end
            end
        end
    end

    // Compare process: every cycle out of reset, between input update and edge.
    initial begin
        logic [1:0]  e_st;
        logic [31:0] e_inst;
        logic [31:0] e_pc;
        forever begin
            @(negedge clk);
            #2;
            if (rst === 1'b1 && chk_en) begin
                if (m_q.size() == 0) begin
                    e_st   = 2'b00;
                    e_inst = 32'd0;
                    e_pc   = m_fetch_pc;
                end else begin
                    e_st   = m_q[0].err ? 2'b01 : 2'b10;
                    e_inst = m_q[0].inst;
                    e_pc   = m_q[0].pc;
                end
                checkOutput("cyc_mem_req", {31'd0, bus.mem_req},
                            {31'd0, (!m_out && (m_q.size() < DEPTH) && !redirect)});
                checkOutput("cyc_mem_addr", bus.mem_addr, m_fetch_pc);
                checkOutput("cyc_status", {30'd0, inst_status}, {30'd0, e_st});
                checkOutput("cyc_inst", inst, e_inst);
                checkOutput("cyc_pc", pc, e_pc);
            end
        end
    end

    // One cycle: drive Decode controls and memory response after the falling
    // edge, then log handshakes and pops seen by the upcoming rising edge.
    task automatic applyStimulus(input bit s, input bit r, input logic [31:0] rpc, input bit g);
        @(negedge clk);
        stall          = s;
        redirect       = r;
        redirect_pc    = rpc;
        bus.mem_gnt    = g;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 32'd0;
        bus.mem_err    = 1'b0;
        if (pend_valid && !resp_hold) begin
            if (pend_delay <= 1) begin
                bus.mem_rvalid = 1'b1;
                bus.mem_rdata  = data_override ? override_data : pend_addr;
                bus.mem_err    = err_en && (pend_addr == err_addr);
                pend_valid     = 0;
                data_override  = 0;
            end else begin
                pend_delay--;
            end
        end
        #3;
        if (rst && bus.mem_req && bus.mem_gnt) begin
            pend_valid = 1;
            pend_delay = lat;
            pend_addr  = bus.mem_addr;
            hs_log.push_back(bus.mem_addr);
        end
        if (rst && inst_status == 2'b10 && !stall && !redirect) begin
            pop_log.push_back(pc);
        end
    endtask

    // Full reset pulse; returns just after release, memory idle.
    task automatic restart();
        @(negedge clk);
        rst            = 1'b0;
        redirect       = 1'b0;
        redirect_pc    = 32'd0;
        stall          = 1'b0;
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 32'd0;
        bus.mem_err    = 1'b0;
        pend_valid     = 0;
        resp_hold      = 0;
        data_override  = 0;
        err_en         = 0;
        lat            = 1;
        @(negedge clk);
        hs_log.delete();
        pop_log.delete();
        m_popped.delete();
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n_valid;
        bit saw_bad;
        rst = 1'b0;
        chk_en = 1;

        // Reset values, then streaming with an always-ready memory.
        restart();
        #3;
        checkOutput("rst_pc", pc, RESET_PC);
        checkOutput("rst_inst", inst, 32'd0);
        checkOutput("rst_status", {30'd0, inst_status}, 32'd0);
        checkOutput("rst_mem_addr", bus.mem_addr, RESET_PC);
        checkOutput("rst_mem_req", {31'd0, bus.mem_req}, 32'd1);
        n_valid = 0;
        for (int i = 0; i < 16; i++) begin
            applyStimulus(0, 0, 32'd0, 1);
            if (inst_status == 2'b10) n_valid++;
        end
        checkOutput("stream_valid_cycles", 32'(n_valid), 32'd7);
        checkOutput("stream_hs_count", 32'(hs_log.size()), 32'd8);
        for (int i = 0; i < 4; i++) begin
            checkOutput("stream_req_addr", hs_log[i], 32'h0040_0000 + 32'(4 * i));
            checkOutput("stream_pop_pc", pop_log[i], 32'h0040_0000 + 32'(4 * i));
        end

        // Stall until full, then drain in order and resume fetching.
        restart();
        for (int i = 0; i < 12; i++) applyStimulus(1, 0, 32'd0, 1);
        checkOutput("full_hs_count", 32'(hs_log.size()), 32'd4);
        checkOutput("full_model_count", 32'(m_q.size()), 32'd4);
        checkOutput("full_mem_req", {31'd0, bus.mem_req}, 32'd0);
        checkOutput("full_head_pc", pc, 32'h0040_0000);
        for (int i = 0; i < 12; i++) applyStimulus(0, 0, 32'd0, 1);
        for (int i = 0; i < 5; i++) begin
            checkOutput("drain_pop_pc", pop_log[i], 32'h0040_0000 + 32'(4 * i));
        end
        checkOutput("resume_req_addr", hs_log[4], 32'h0040_0010);

        // Redirect while waiting; the late response must be discarded.
        restart();
        lat           = 4;
        data_override = 1;
        override_data = 32'hDEAD_BEEF;
        saw_bad       = 0;
        applyStimulus(0, 0, 32'd0, 1);
        lat = 1;
        applyStimulus(0, 1, 32'h0040_0100, 1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 32'd0, 1);
            if (inst == 32'hDEAD_BEEF) saw_bad = 1;
        end
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 0, 32'd0, 1);
            if (inst == 32'hDEAD_BEEF) saw_bad = 1;
        end
        checkOutput("drop_never_shown", {31'd0, saw_bad}, 32'd0);
        checkOutput("drop_next_req", hs_log[1], 32'h0040_0100);
        checkOutput("drop_head_pc", pc, 32'h0040_0100);
        checkOutput("drop_head_status", {30'd0, inst_status}, 32'd2);

        // Redirect together with a response and a would-be pop.
        restart();
        for (int i = 0; i < 5; i++) applyStimulus(1, 0, 32'd0, 1);
        applyStimulus(0, 1, 32'h0040_0200, 1);
        applyStimulus(1, 0, 32'd0, 0);
        checkOutput("coinc_status", {30'd0, inst_status}, 32'd0);
        checkOutput("coinc_mem_addr", bus.mem_addr, 32'h0040_0200);
        checkOutput("coinc_mem_req", {31'd0, bus.mem_req}, 32'd1);
        checkOutput("coinc_model_empty", 32'(m_q.size()), 32'd0);

        // Bus error on 0x00400008 sticks at the head until redirect.
        restart();
        err_en   = 1;
        err_addr = 32'h0040_0008;
        for (int i = 0; i < 16; i++) applyStimulus(0, 0, 32'd0, 1);
        checkOutput("err_status", {30'd0, inst_status}, 32'd1);
        checkOutput("err_pc", pc, 32'h0040_0008);
        checkOutput("err_mem_req", {31'd0, bus.mem_req}, 32'd0);
        checkOutput("err_pop_count", 32'(pop_log.size()), 32'd2);
        checkOutput("err_pop1", pop_log[1], 32'h0040_0004);
        checkOutput("err_model_pops", 32'(m_popped.size()), 32'd2);
        for (int i = 0; i < 4; i++) applyStimulus(1, 0, 32'd0, 1);
        checkOutput("err_hold_status", {30'd0, inst_status}, 32'd1);
        applyStimulus(0, 1, 32'h0040_0300, 0);
        applyStimulus(0, 0, 32'd0, 0);
        checkOutput("err_cleared_status", {30'd0, inst_status}, 32'd0);
        checkOutput("err_cleared_pc", pc, 32'h0040_0300);

        // Asynchronous reset while waiting on a response; stale data ignored.
        restart();
        for (int i = 0; i < 6; i++) applyStimulus(1, 0, 32'd0, 1);
        lat = 3;
        applyStimulus(1, 0, 32'd0, 1);
        resp_hold = 1;
        @(negedge clk);
        #1 rst = 1'b0;
        #1;
        checkOutput("arst_status", {30'd0, inst_status}, 32'd0);
        checkOutput("arst_inst", inst, 32'd0);
        checkOutput("arst_pc", pc, RESET_PC);
        checkOutput("arst_mem_addr", bus.mem_addr, RESET_PC);
        hs_log.delete();
        @(negedge clk);
        rst         = 1'b1;
        bus.mem_gnt = 1'b0;
        stall       = 1'b0;
        lat         = 1;
        resp_hold   = 0;
        pend_delay  = 1;
        applyStimulus(0, 0, 32'd0, 0);
        checkOutput("stale_status", {30'd0, inst_status}, 32'd0);
        checkOutput("stale_mem_req", {31'd0, bus.mem_req}, 32'd1);
        for (int i = 0; i < 4; i++) applyStimulus(1, 0, 32'd0, 1);
        checkOutput("arst_first_req", hs_log[0], RESET_PC);
        checkOutput("arst_head_pc", pc, RESET_PC);
        checkOutput("arst_head_status", {30'd0, inst_status}, 32'd2);

        chk_en = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
